// File: rtl/dff_frame_deserializer.sv
// Frames a qualified serial bit stream (start, WIDTH data, stop) into words,
// buffers them in a DEPTH-entry FIFO and presents them on valid/ready.
// Ports:
//   clk, rst       clock, async active-low reset
//   bit_valid      qualifies bit_in this cycle
//   bit_in         serial data bit
//   out_data       head-of-FIFO word
//   out_valid      FIFO non-empty
//   out_ready      consumer accepts the head word
//   level          number of stored words
//   overflow       sticky: good frame dropped because the FIFO was full
//   frame_err      sticky: stop bit was 1
//   clr_err        synchronous clear of both sticky flags
module dff_frame_deserializer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bit_valid,
  input  logic                       bit_in,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic                       frame_err,
  input  logic                       clr_err
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_STOP
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] asm_q;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_d;
  logic             ovf_q;
  logic             ferr_q;

  logic push_req;
  logic bad_stop;
  logic full;
  logic pop;
  logic push;
  logic ovf_set;

  assign push_req = (state_q == S_STOP) && bit_valid && !bit_in;
  assign bad_stop = (state_q == S_STOP) && bit_valid && bit_in;
  assign full     = (level_q == LW'(DEPTH));
  assign pop      = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign level_d  = level_q + LW'(push) - LW'(pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      asm_q   <= '0;
    end else if (bit_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (bit_in) begin
            state_q <= S_SHIFT;
            cnt_q   <= '0;
          end
        end
        S_SHIFT: begin
          if (MSB_FIRST) asm_q <= {asm_q[WIDTH-2:0], bit_in};
          else           asm_q <= {bit_in, asm_q[WIDTH-1:1]};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_q <= S_STOP;
        end
        S_STOP: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= asm_q;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      level_q <= level_d;
      // Set wins over a coincident clear.
      ovf_q  <= ovf_set  | (ovf_q  & ~clr_err);
      ferr_q <= bad_stop | (ferr_q & ~clr_err);
    end
  end

  assign out_data  = mem_q[rd_q];
  assign out_valid = (level_q != '0);
  assign level     = level_q;
  assign overflow  = ovf_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_dff_frame_deserializer.sv
// Directed bench for dff_frame_deserializer: MSB and LSB instances
// share one bit stream; expected words are hand-computed.
module tb_dff_frame_deserializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       out_ready = 1'b0;
  logic       clr_err = 1'b0;

  logic [7:0] m_data, l_data;
  logic       m_valid, l_valid;
  logic [2:0] m_level, l_level;
  logic       m_ovf, l_ovf;
  logic       m_ferr, l_ferr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dff_frame_deserializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
    .out_data(m_data), .out_valid(m_valid), .out_ready(out_ready),
    .level(m_level), .overflow(m_ovf), .frame_err(m_ferr),
    .clr_err(clr_err)
  );

  dff_frame_deserializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
    .out_data(l_data), .out_valid(l_valid), .out_ready(out_ready),
    .level(l_level), .overflow(l_ovf), .frame_err(l_ferr),
    .clr_err(clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic b, input bit gap);
    @(negedge clk);
    bit_valid = 1'b1;
    bit_in    = b;
    if (gap) begin
      @(negedge clk);
      bit_valid = 1'b0;
      bit_in    = 1'b0;
    end
  endtask

  // Leaves the caller at the negedge after the stop bit was sampled.
  task automatic send_frame(input logic [7:0] d, input logic stopb,
                            input bit gap, input logic rdy);
    put(1'b1, gap);
    for (int i = 7; i >= 0; i--) put(d[i], gap);
    @(negedge clk);
    bit_valid = 1'b1;
    bit_in    = stopb;
    out_ready = rdy;
    @(negedge clk);
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic pop_one(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, 32'(m_valid), 32'd1);
    chk({tag, "_data"}, 32'(m_data), 32'(exp));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_level", 32'(m_level), 32'd0);
    chk("rst_data",  32'(m_data),  32'd0);
    chk("rst_ovf",   32'(m_ovf),   32'd0);
    chk("rst_ferr",  32'(m_ferr),  32'd0);
    rst = 1'b1;

    // Basic MSB frame
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    chk("basic_valid", 32'(m_valid), 32'd1);
    chk("basic_data",  32'(m_data),  32'hA5);
    chk("basic_level", 32'(m_level), 32'd1);
    chk("basic_ovf",   32'(m_ovf),   32'd0);
    chk("basic_ferr",  32'(m_ferr),  32'd0);
    chk("basic_lsb",   32'(l_data),  32'hA5);
    pop_one("basic_pop", 8'hA5);
    chk("basic_empty", 32'(m_level), 32'd0);

    // LSB order with gaps
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    chk("gap_lsb_valid", 32'(l_valid), 32'd1);
    chk("gap_lsb_data",  32'(l_data),  32'hA5);
    chk("gap_lsb_level", 32'(l_level), 32'd1);
    pop_one("gap_pop", 8'hA5);

    // Framing error, clear, then good frame
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    chk("ferr_set",   32'(m_ferr),  32'd1);
    chk("ferr_level", 32'(m_level), 32'd0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("ferr_clr", 32'(m_ferr), 32'd0);
    send_frame(8'h11, 1'b0, 1'b0, 1'b0);
    chk("after_ferr_data", 32'(m_data), 32'h11);
    chk("after_ferr_lsb",  32'(l_data), 32'h88);
    chk("after_ferr_flag", 32'(m_ferr), 32'd0);
    pop_one("after_ferr_pop", 8'h11);

    // Overflow
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b0, 1'b0, 1'b0);
    chk("ovf_level", 32'(m_level), 32'd4);
    chk("ovf_flag",  32'(m_ovf),   32'd1);
    for (int k = 1; k <= 4; k++) pop_one("ovf_drain", 8'(k));
    chk("ovf_empty", 32'(m_valid), 32'd0);
    chk("ovf_lvl0",  32'(m_level), 32'd0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("ovf_clr", 32'(m_ovf), 32'd0);

    // Full FIFO with simultaneous pop on the stop-bit cycle
    send_frame(8'h10, 1'b0, 1'b0, 1'b0);
    send_frame(8'h20, 1'b0, 1'b0, 1'b0);
    send_frame(8'h30, 1'b0, 1'b0, 1'b0);
    send_frame(8'h40, 1'b0, 1'b0, 1'b0);
    chk("full_level", 32'(m_level), 32'd4);
    send_frame(8'h77, 1'b0, 1'b0, 1'b1);
    chk("fullpop_ovf",   32'(m_ovf),   32'd0);
    chk("fullpop_level", 32'(m_level), 32'd4);
    pop_one("fullpop_d0", 8'h20);
    pop_one("fullpop_d1", 8'h30);
    pop_one("fullpop_d2", 8'h40);
    pop_one("fullpop_d3", 8'h77);
    chk("fullpop_empty", 32'(m_valid), 32'd0);

    // Mid-frame reset
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_level", 32'(m_level), 32'd1);
    put(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) put(1'b1, 1'b0);
    @(negedge clk);
    bit_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mrst_valid", 32'(m_valid), 32'd0);
    chk("mrst_level", 32'(m_level), 32'd0);
    chk("mrst_data",  32'(m_data),  32'd0);
    chk("mrst_ovf",   32'(m_ovf),   32'd0);
    chk("mrst_ferr",  32'(m_ferr),  32'd0);
    @(negedge clk);
    rst = 1'b1;
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0);
    chk("post_rst_level", 32'(m_level), 32'd1);
    pop_one("post_rst_pop", 8'hC3);
    repeat (3) @(negedge clk);
    chk("post_rst_empty", 32'(m_valid), 32'd0);
    chk("post_rst_lvl0",  32'(m_level), 32'd0);
    chk("post_rst_ferr",  32'(m_ferr),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
